lb_pulse_stretcher: RTL and testbench

Converts single-cycle strobes (as produced by the lb_pulseMaker edge detector) back into level pulses of programmable high time. It also enforces a programmable minimum low gap between output pulses. It sits on the consumer side of strobe-based links, e.g. driving LEDs, external enables or slow peripherals from one-cycle events. Three handling policies cover strobes that arrive while an output pulse is in progress: ignore, retrigger (extend) and queue (count and replay).

---
 rtl/lb_pulse_stretcher_pkg.sv | 14 +
 rtl/lb_pulse_stretcher_sat_counter.sv | 32 +++
 rtl/lb_pulse_stretcher.sv | 118 +++++++++++
 tb/tb_lb_pulse_stretcher.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lb_pulse_stretcher_pkg.sv
// Shared constants for the pulse stretcher: strobe handling modes and FSM state encoding.
package lb_pulse_pkg;

    localparam logic [1:0] MODE_IGNORE = 2'd0;
    localparam logic [1:0] MODE_RETRIG = 2'd1;
    localparam logic [1:0] MODE_QUEUE  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/lb_pulse_stretcher_sat_counter.sv
// Up/down counter that saturates at all-ones and latches a sticky overflow flag
// when an increment is refused.
module lb_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow
);

    localparam logic [W-1:0] COUNT_MAX = '1;

    // A simultaneous inc and dec cancels, even at saturation, so no strobe is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == COUNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/lb_pulse_stretcher.sv
// Stretches single-cycle strobes into level pulses of programmable length with a
// programmable minimum low gap; overlapping strobes are ignored, retrigger or queue.
module lb_pulse_stretcher
    import lb_pulse_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int PEND_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    input  logic [CNT_W-1:0]  len,
    input  logic [CNT_W-1:0]  gap,
    input  logic [1:0]        mode,
    output logic              signal_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   len_load;
    logic               mode_queue;
    logic               mode_retrig;
    logic               pend_inc;
    logic               pend_dec;

    // A programmed length of zero still produces a one-cycle pulse.
    function automatic logic [CNT_W-1:0] len_to_load(input logic [CNT_W-1:0] v);
        if (v == '0) begin
            return '0;
        end
        return v - 1'b1;
    endfunction

    assign len_load    = len_to_load(len);
    assign mode_queue  = (mode == MODE_QUEUE);
    assign mode_retrig = (mode == MODE_RETRIG);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A strobe queued in the very cycle a slot frees up is consumed directly;
    // counting it as available keeps pending at zero whenever the FSM is idle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_inc  = 1'b0;
        pend_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = len_load;
                end
            end
            ST_HIGH: begin
                pend_inc = pulse_in && mode_queue;
                if (pulse_in && mode_retrig) begin
                    cnt_nxt = len_load;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if (gap != '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = gap - 1'b1;
                end else if ((pending != '0) || pend_inc) begin
                    cnt_nxt  = len_load;
                    pend_dec = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                pend_inc = pulse_in && mode_queue;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else if ((pending != '0) || pend_inc) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = len_load;
                    pend_dec  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        signal_out = (state == ST_HIGH);
        busy       = (state != ST_IDLE);
    end

    lb_sat_counter #(
        .W (PEND_W)
    ) u_pending (
        .clk      (clk),
        .reset    (reset),
        .inc      (pend_inc),
        .dec      (pend_dec),
        .count    (pending),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_lb_pulse_stretcher.sv
// Bench for lb_pulse_stretcher: per-cycle vector table through an expected-output
// queue, plus hand-written saturation and reset-during-pulse sequences.
module tb_lb_pulse_stretcher;
    import lb_pulse_pkg::*;

    localparam int CNT_W  = 16;
    localparam int PEND_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              pulse_in;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  gap;
    logic [1:0]        mode;
    logic              signal_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    lb_pulse_stretcher #(
        .CNT_W  (CNT_W),
        .PEND_W (PEND_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pulse_in   (pulse_in),
        .len        (len),
        .gap        (gap),
        .mode       (mode),
        .signal_out (signal_out),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       pin;
        int         len;
        int         gap;
        logic [1:0] mode;
        logic       sig;
        logic       busy;
        int         pend;
        logic       ovf;
    } vec_t;

    typedef struct packed {
        logic       sig;
        logic       busy;
        logic [1:0] pend;
        logic       ovf;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   pulses = 0;
    int   max_pend = 0;
    logic prev_sig = 1'b0;

    task automatic add(input string nm, input logic r, input logic p, input int l, input int g,
                       input logic [1:0] m, input logic s, input logic b, input int pd, input logic o);
        vec_t v;
        v.name = nm; v.rst = r; v.pin = p; v.len = l; v.gap = g; v.mode = m;
        v.sig = s; v.busy = b; v.pend = pd; v.ovf = o;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t act;
        reset    = v.rst;
        pulse_in = v.pin;
        len      = CNT_W'(v.len);
        gap      = CNT_W'(v.gap);
        mode     = v.mode;
        e.sig = v.sig; e.busy = v.busy; e.pend = 2'(v.pend); e.ovf = v.ovf;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e   = sb.pop_front();
        act = {signal_out, busy, pending, overflow};
        n_vec++;
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s: got sig=%b busy=%b pend=%0d ovf=%b, want sig=%b busy=%b pend=%0d ovf=%b",
                     v.name, act.sig, act.busy, act.pend, act.ovf, e.sig, e.busy, e.pend, e.ovf);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic clock_and_track();
        @(posedge clk);
        @(negedge clk);
        if (signal_out && !prev_sig) pulses++;
        prev_sig = signal_out;
        if (int'(pending) > max_pend) max_pend = int'(pending);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; pulse_in = 1'b0; len = '0; gap = '0; mode = MODE_IGNORE;

        // Reset and ignore mode: len=3, gap=2; strobes during HIGH and GAP are dropped.
        add("reset",      1, 0, 3, 2, MODE_IGNORE, 0, 0, 0, 0);
        add("reset_pin",  1, 1, 3, 2, MODE_IGNORE, 0, 0, 0, 0);
        add("idle",       0, 0, 3, 2, MODE_IGNORE, 0, 0, 0, 0);
        add("ign_strobe", 0, 1, 3, 2, MODE_IGNORE, 1, 1, 0, 0);
        add("ign_hi_pin", 0, 1, 3, 2, MODE_IGNORE, 1, 1, 0, 0);
        add("ign_hi3",    0, 0, 3, 2, MODE_IGNORE, 1, 1, 0, 0);
        add("ign_gap1",   0, 0, 3, 2, MODE_IGNORE, 0, 1, 0, 0);
        add("ign_gap_pin",0, 1, 3, 2, MODE_IGNORE, 0, 1, 0, 0);
        add("ign_idle",   0, 0, 3, 2, MODE_IGNORE, 0, 0, 0, 0);
        add("ign_idle2",  0, 0, 3, 2, MODE_IGNORE, 0, 0, 0, 0);
        // len=0 acts as one cycle.
        add("len0_strobe",0, 1, 0, 0, MODE_IGNORE, 1, 1, 0, 0);
        add("len0_end",   0, 0, 0, 0, MODE_IGNORE, 0, 0, 0, 0);
        add("len0_idle",  0, 0, 0, 0, MODE_IGNORE, 0, 0, 0, 0);
        // Retrigger len=4 gap=0: second strobe two cycles later extends to 6 cycles.
        add("rt_strobe",  0, 1, 4, 0, MODE_RETRIG, 1, 1, 0, 0);
        add("rt_h2",      0, 0, 4, 0, MODE_RETRIG, 1, 1, 0, 0);
        add("rt_retrig",  0, 1, 4, 0, MODE_RETRIG, 1, 1, 0, 0);
        add("rt_h4",      0, 0, 4, 0, MODE_RETRIG, 1, 1, 0, 0);
        add("rt_h5",      0, 0, 4, 0, MODE_RETRIG, 1, 1, 0, 0);
        add("rt_h6",      0, 0, 4, 0, MODE_RETRIG, 1, 1, 0, 0);
        add("rt_end",     0, 0, 4, 0, MODE_RETRIG, 0, 0, 0, 0);
        // Retrigger len=2 gap=3: strobe inside the gap gives no second pulse.
        add("rtg_strobe", 0, 1, 2, 3, MODE_RETRIG, 1, 1, 0, 0);
        add("rtg_h2",     0, 0, 2, 3, MODE_RETRIG, 1, 1, 0, 0);
        add("rtg_gap1",   0, 0, 2, 3, MODE_RETRIG, 0, 1, 0, 0);
        add("rtg_gap_pin",0, 1, 2, 3, MODE_RETRIG, 0, 1, 0, 0);
        add("rtg_gap3",   0, 0, 2, 3, MODE_RETRIG, 0, 1, 0, 0);
        add("rtg_idle",   0, 0, 2, 3, MODE_RETRIG, 0, 0, 0, 0);
        add("rtg_idle2",  0, 0, 2, 3, MODE_RETRIG, 0, 0, 0, 0);
        // Queue len=2 gap=1: three consecutive strobes replay as three pulses.
        add("q_s1",       0, 1, 2, 1, MODE_QUEUE, 1, 1, 0, 0);
        add("q_s2",       0, 1, 2, 1, MODE_QUEUE, 1, 1, 1, 0);
        add("q_s3",       0, 1, 2, 1, MODE_QUEUE, 0, 1, 2, 0);
        add("q_p2_h1",    0, 0, 2, 1, MODE_QUEUE, 1, 1, 1, 0);
        add("q_p2_h2",    0, 0, 2, 1, MODE_QUEUE, 1, 1, 1, 0);
        add("q_p2_gap",   0, 0, 2, 1, MODE_QUEUE, 0, 1, 1, 0);
        add("q_p3_h1",    0, 0, 2, 1, MODE_QUEUE, 1, 1, 0, 0);
        add("q_p3_h2",    0, 0, 2, 1, MODE_QUEUE, 1, 1, 0, 0);
        add("q_p3_gap",   0, 0, 2, 1, MODE_QUEUE, 0, 1, 0, 0);
        add("q_idle",     0, 0, 2, 1, MODE_QUEUE, 0, 0, 0, 0);
        // Queue gap=0: strobe on the last high cycle merges into a continuous level.
        add("qm_s1",      0, 1, 1, 0, MODE_QUEUE, 1, 1, 0, 0);
        add("qm_merge",   0, 1, 1, 0, MODE_QUEUE, 1, 1, 0, 0);
        add("qm_end",     0, 0, 1, 0, MODE_QUEUE, 0, 0, 0, 0);
        // Queued entry still drains after switching to ignore.
        add("qd_s1",      0, 1, 3, 1, MODE_QUEUE,  1, 1, 0, 0);
        add("qd_s2",      0, 1, 3, 1, MODE_QUEUE,  1, 1, 1, 0);
        add("qd_sw",      0, 0, 3, 1, MODE_IGNORE, 1, 1, 1, 0);
        add("qd_gap",     0, 0, 3, 1, MODE_IGNORE, 0, 1, 1, 0);
        add("qd_h1",      0, 0, 3, 1, MODE_IGNORE, 1, 1, 0, 0);
        add("qd_h2",      0, 0, 3, 1, MODE_IGNORE, 1, 1, 0, 0);
        add("qd_h3",      0, 0, 3, 1, MODE_IGNORE, 1, 1, 0, 0);
        add("qd_gap2",    0, 0, 3, 1, MODE_IGNORE, 0, 1, 0, 0);
        add("qd_idle",    0, 0, 3, 1, MODE_IGNORE, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Saturation: eight back-to-back strobes with len=8 against a 3-deep queue.
        len = 16'd8; gap = 16'd2; mode = MODE_QUEUE; reset = 1'b0;
        pulses = 0; max_pend = 0; prev_sig = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pulse_in = 1'b1;
            clock_and_track();
        end
        pulse_in = 1'b0;
        chk("sat_pending", int'(pending), 3);
        chk("sat_overflow", int'(overflow), 1);
        for (int c = 0; c < 200 && busy; c++) begin
            clock_and_track();
        end
        chk("sat_drained", int'(busy), 0);
        chk("sat_pulses", pulses, 4);
        chk("sat_max_pending", max_pend, 3);
        chk("sat_ovf_sticky", int'(overflow), 1);
        chk("sat_pending_end", int'(pending), 0);

        // Reset while HIGH with pending=2; the strobe in the reset cycle is discarded.
        vecs.delete();
        add("rs_s1",      0, 1, 5, 1, MODE_QUEUE, 1, 1, 0, 1);
        add("rs_s2",      0, 1, 5, 1, MODE_QUEUE, 1, 1, 1, 1);
        add("rs_s3",      0, 1, 5, 1, MODE_QUEUE, 1, 1, 2, 1);
        add("rs_reset",   1, 1, 5, 1, MODE_QUEUE, 0, 0, 0, 0);
        add("rs_after1",  0, 0, 5, 1, MODE_QUEUE, 0, 0, 0, 0);
        add("rs_after2",  0, 0, 5, 1, MODE_QUEUE, 0, 0, 0, 0);
        add("rs_after3",  0, 0, 5, 1, MODE_QUEUE, 0, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
